// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the execute-stage memory port.
// Services AGU load/store requests from an internal word-organised RAM after
// WAIT_CYCLES wait states, returning a one-cycle completion pulse, the full
// read word, and an out-of-range fault flag.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   mem_req_i           request valid
//   mem_we_i            1 = store, 0 = load
//   mem_raddr_i         byte read address (loads)
//   mem_waddr_i         byte write address (stores)
//   mem_wdata_i         lane-aligned store data
//   mem_wmask_i         byte write enables
//   mem_gnt_o           request can be accepted this cycle
//   mem_rvalid_o        one-cycle completion pulse
//   mem_rdata_o         read word, qualified by mem_rvalid_o
//   mem_err_o           access fault, qualified by mem_rvalid_o
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_raddr_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wmask_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_err_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LD = 3'(WAIT_CYCLES);
  localparam logic [29:0] BASE_W  = ADDR_BASE[31:2];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Latched request; only the word address is kept since addr[1:0] is ignored.
  typedef struct packed {
    logic        we;
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  state_t state, state_nxt;
  logic [2:0] cnt;
  req_t req_q, req_in, req_cur;
  logic accept, enter_resp, commit, in_range;
  logic [29:0] woff;
  logic [AW-1:0] idx;

  logic [3:0][7:0] ram [DEPTH_WORDS];

  // Low address bits select bytes within the word; the requester handles that.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{mem_raddr_i[1:0], mem_waddr_i[1:0]};

  assign mem_gnt_o    = (state != WAIT);
  assign mem_rvalid_o = (state == RESP);
  assign accept       = mem_req_i & mem_gnt_o;

  assign req_in = '{we:    mem_we_i,
                    waddr: mem_we_i ? mem_waddr_i[31:2] : mem_raddr_i[31:2],
                    wdata: mem_wdata_i,
                    wmask: mem_wmask_i};

  // With zero wait states the commit edge is the accept edge itself, so the
  // live inputs are used; otherwise the latched copy is.
  assign req_cur = accept ? req_in : req_q;

  assign woff     = req_cur.waddr - BASE_W;
  assign in_range = (req_cur.waddr >= BASE_W) && (woff[29:AW] == '0);
  assign idx      = woff[AW-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (accept) state_nxt = (WAIT_LD == 3'd0) ? RESP : WAIT;
        else        state_nxt = IDLE;
      end
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP);
  // Gate with reset so a request held during reset cannot touch the RAM.
  assign commit     = enter_resp & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      req_q       <= '0;
      mem_rdata_o <= 32'd0;
      mem_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= WAIT_LD;
        req_q <= req_in;
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
      end
      if (enter_resp) begin
        mem_err_o <= ~in_range;
        if (!in_range)        mem_rdata_o <= 32'd0;
        else if (!req_cur.we) mem_rdata_o <= ram[idx];
      end
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && req_cur.we && in_range) begin
      for (int b = 0; b < 4; b++)
        if (req_cur.wmask[b]) ram[idx][b] <= req_cur.wdata[8*b +: 8];
    end
  end

endmodule
